// File: rtl/stack_op_sequencer_if.sv
// Command/result handshake between a host and the stack operation sequencer.
// The host drives the command fields; the sequencer answers with ready and result pulses.
interface stack_op_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_imm;
    logic       res_valid;
    logic [7:0] res_data;

    modport master (
        output cmd_valid, cmd_op, cmd_imm,
        input  cmd_ready, res_valid, res_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_imm,
        output cmd_ready, res_valid, res_data
    );
endinterface

// File: rtl/stack_op_sequencer.sv
// Sole master of an 8-bit operand stack: sequences PUSH/POP/DUP/ALU commands with occupancy checks.
// Optional ALU flags zf/cf are built when STACK_SEQ_FLAGS_EN is defined.
module stack_op_sequencer #(
    parameter int DEPTH = 5,
    parameter int CW    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    stack_op_sequencer_if.slave  bus,
    output logic                 stk_push,
    output logic                 stk_pop,
    output logic                 stk_tos,
    output logic [7:0]           stk_din,
    input  logic [7:0]           stk_dout,
    output logic                 err,
    output logic [CW-1:0]        depth
`ifdef STACK_SEQ_FLAGS_EN
    ,
    output logic                 zf,
    output logic                 cf
`endif
);

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_DUP  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_OR   = 3'd6;
    localparam logic [2:0] OP_NOT  = 3'd7;

    typedef enum logic [2:0] {
        IDLE, RD_A, RD_B, EXEC, WR, DONE, FAULT
    } state_t;

    state_t        state_reg, state_next;
    logic [2:0]    op_reg, op_next;
    logic [7:0]    a_reg, a_next;
    logic [7:0]    b_reg, b_next;
    logic          push_reg, push_next;
    logic          pop_reg, pop_next;
    logic          tos_reg, tos_next;
    logic [7:0]    din_reg, din_next;
    logic          ready_reg, ready_next;
    logic          res_valid_reg, res_valid_next;
    logic [7:0]    res_data_reg, res_data_next;
    logic          err_reg, err_next;
    logic [CW-1:0] depth_reg, depth_next;

    logic          accept;
    logic [1:0]    needs;
    logic          grows;
    logic          underflow;
    logic          overflow;
    logic [7:0]    alu_r;

    assign accept = bus.cmd_valid & ready_reg & (state_reg == IDLE);

    // Operand demand and upward growth of the incoming command, used to reject it before any strobe.
    always_comb begin
        needs = 2'd1;
        grows = 1'b0;
        case (bus.cmd_op)
            OP_PUSH: begin needs = 2'd0; grows = 1'b1; end
            OP_DUP:  begin needs = 2'd1; grows = 1'b1; end
            OP_POP,
            OP_NOT:  needs = 2'd1;
            default: needs = 2'd2;
        endcase
        underflow = ({1'b0, depth_reg} < {{(CW-1){1'b0}}, needs});
        overflow  = grows && (depth_reg == CW'(DEPTH));
    end

    // A is the former top, B the element beneath it.
    always_comb begin
        alu_r = 8'h00;
        case (op_reg)
            OP_ADD:  alu_r = a_reg + b_reg;
            OP_SUB:  alu_r = b_reg - a_reg;
            OP_AND:  alu_r = a_reg & b_reg;
            OP_OR:   alu_r = a_reg | b_reg;
            OP_NOT:  alu_r = ~a_reg;
            default: alu_r = 8'h00;
        endcase
    end

    // Outputs are computed for the state being entered so every strobe leaves a flop.
    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        a_next         = a_reg;
        b_next         = b_reg;
        push_next      = 1'b0;
        pop_next       = 1'b0;
        tos_next       = 1'b0;
        din_next       = din_reg;
        res_valid_next = 1'b0;
        res_data_next  = res_data_reg;
        err_next       = err_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    op_next = bus.cmd_op;
                    if (underflow || overflow) begin
                        state_next     = FAULT;
                        err_next       = 1'b1;
                        res_valid_next = 1'b1;
                        res_data_next  = 8'h00;
                    end else if (bus.cmd_op == OP_PUSH) begin
                        state_next = WR;
                        push_next  = 1'b1;
                        din_next   = bus.cmd_imm;
                    end else begin
                        state_next = RD_A;
                        tos_next   = 1'b1;
                        pop_next   = (bus.cmd_op != OP_DUP);
                    end
                end
            end
            RD_A: begin
                a_next = stk_dout;
                case (op_reg)
                    OP_POP: begin
                        state_next     = DONE;
                        res_valid_next = 1'b1;
                        res_data_next  = stk_dout;
                    end
                    OP_DUP: begin
                        state_next = WR;
                        push_next  = 1'b1;
                        din_next   = stk_dout;
                    end
                    OP_NOT:  state_next = EXEC;
                    default: begin
                        state_next = RD_B;
                        tos_next   = 1'b1;
                        pop_next   = 1'b1;
                    end
                endcase
            end
            RD_B: begin
                b_next     = stk_dout;
                state_next = EXEC;
            end
            EXEC: begin
                state_next = WR;
                push_next  = 1'b1;
                din_next   = alu_r;
            end
            WR: begin
                state_next     = DONE;
                res_valid_next = 1'b1;
                res_data_next  = din_reg;
            end
            default: state_next = IDLE;
        endcase

        ready_next = (state_next == IDLE);
        if (push_next)
            depth_next = depth_reg + 1'b1;
        else if (pop_next)
            depth_next = depth_reg - 1'b1;
        else
            depth_next = depth_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            op_reg        <= 3'd0;
            a_reg         <= 8'h00;
            b_reg         <= 8'h00;
            push_reg      <= 1'b0;
            pop_reg       <= 1'b0;
            tos_reg       <= 1'b0;
            din_reg       <= 8'h00;
            ready_reg     <= 1'b0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= 8'h00;
            err_reg       <= 1'b0;
            depth_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            push_reg      <= push_next;
            pop_reg       <= pop_next;
            tos_reg       <= tos_next;
            din_reg       <= din_next;
            ready_reg     <= ready_next;
            res_valid_reg <= res_valid_next;
            res_data_reg  <= res_data_next;
            err_reg       <= err_next;
            depth_reg     <= depth_next;
        end
    end

`ifdef STACK_SEQ_FLAGS_EN
    logic       zf_reg, cf_reg;
    logic [8:0] sum9;

    assign sum9 = {1'b0, a_reg} + {1'b0, b_reg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zf_reg <= 1'b0;
            cf_reg <= 1'b0;
        end else if (state_reg == EXEC) begin
            zf_reg <= (alu_r == 8'h00);
            case (op_reg)
                OP_ADD:  cf_reg <= sum9[8];
                OP_SUB:  cf_reg <= (a_reg > b_reg);
                default: cf_reg <= 1'b0;
            endcase
        end
    end

    assign zf = zf_reg;
    assign cf = cf_reg;
`endif

    assign bus.cmd_ready = ready_reg;
    assign bus.res_valid = res_valid_reg;
    assign bus.res_data  = res_data_reg;
    assign stk_push      = push_reg;
    assign stk_pop       = pop_reg;
    assign stk_tos       = tos_reg;
    assign stk_din       = din_reg;
    assign err           = err_reg;
    assign depth         = depth_reg;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: queue-based reference model, external stack device, directed commands.
module tb_stack_op_sequencer;
    localparam int DEPTH = 5;
    localparam int CW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    stack_op_sequencer_if bus();
    logic          stk_push, stk_pop, stk_tos;
    logic [7:0]    stk_din, stk_dout;
    logic          err;
    logic [CW-1:0] depth;
`ifdef STACK_SEQ_FLAGS_EN
    logic          zf, cf;
`endif

    stack_op_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .stk_push (stk_push),
        .stk_pop  (stk_pop),
        .stk_tos  (stk_tos),
        .stk_din  (stk_din),
        .stk_dout (stk_dout),
        .err      (err),
        .depth    (depth)
`ifdef STACK_SEQ_FLAGS_EN
        ,
        .zf       (zf),
        .cf       (cf)
`endif
    );

    // External stack device driven only by the sequencer strobes.
    logic [7:0] mem [0:7];
    logic [3:0] sp;
    always @(posedge clk or negedge rst) begin
        if (!rst) sp <= 4'd0;
        else if (stk_push) begin
            mem[sp[2:0]] <= stk_din;
            sp <= sp + 4'd1;
        end else if (stk_pop) sp <= sp - 4'd1;
    end
    assign stk_dout = (stk_tos && sp != 4'd0) ? mem[sp[2:0] - 3'd1] : 8'h00;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [7:0] ref_q[$];
    logic       err_m = 1'b0;
    logic       mz = 1'b0, mc = 1'b0;
    int         model_depth = 0;
    logic       model_err = 1'b0;

    // Expectations for the command in flight
    bit         busy = 0;
    bit         in_reset = 1;
    int         lat, n_push, n_pop;
    int         exp_lat, exp_npush, exp_npop, exp_depth_after;
    logic [7:0] exp_res, exp_din, last_res;
    logic       exp_err_after, exp_zf, exp_cf;
    logic [2:0] cur_op;

    always @(negedge clk) begin
        if (rst && !in_reset) begin
            chk("one_strobe", {31'b0, stk_push & stk_pop}, 32'd0);
            chk("depth_range", {31'b0, depth <= CW'(DEPTH)}, 32'd1);
            if (busy) begin
                lat++;
                if (stk_push) begin
                    n_push++;
                    chk("stk_din", stk_din, exp_din);
                end
                if (stk_pop) n_pop++;
                if (bus.res_valid) begin
                    chk("res_data", bus.res_data, exp_res);
                    chk("latency", lat, exp_lat);
                    chk("push_count", n_push, exp_npush);
                    chk("pop_count", n_pop, exp_npop);
                    chk("err", err, exp_err_after);
`ifdef STACK_SEQ_FLAGS_EN
                    chk("zf", zf, exp_zf);
                    chk("cf", cf, exp_cf);
`endif
                    $display("op=%0d res=%02h exp=%02h lat=%0d push=%0d pop=%0d err=%0b",
                             cur_op, bus.res_data, exp_res, lat, n_push, n_pop, err);
                    last_res    = bus.res_data;
                    model_depth = exp_depth_after;
                    model_err   = exp_err_after;
                    busy        = 0;
                end else if (lat > 8) begin
                    chk("res_timeout", 32'd0, 32'd1);
                    busy = 0;
                end
            end else if (bus.cmd_ready) begin
                chk("idle_depth", depth, model_depth);
                chk("idle_err", err, model_err);
                chk("idle_quiet", {28'b0, stk_push, stk_pop, stk_tos, bus.res_valid}, 32'd0);
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [7:0] imm);
        int         needs;
        bit         fault;
        logic [7:0] a, b, r;
        logic [8:0] s9;
        logic       c;
        needs = (op == 3'd0) ? 0 : ((op >= 3'd3 && op <= 3'd6) ? 2 : 1);
        fault = (ref_q.size() < needs) || ((op == 3'd0 || op == 3'd2) && ref_q.size() == DEPTH);
        exp_npush = 0; exp_npop = 0; exp_din = 8'h00; cur_op = op;
        if (fault) begin
            exp_res = 8'h00; exp_lat = 1; err_m = 1'b1;
        end else begin
            case (op)
                3'd0: begin ref_q.push_back(imm); exp_res = imm; exp_din = imm; exp_npush = 1; exp_lat = 2; end
                3'd1: begin exp_res = ref_q.pop_back(); exp_npop = 1; exp_lat = 2; end
                3'd2: begin a = ref_q[$]; ref_q.push_back(a); exp_res = a; exp_din = a; exp_npush = 1; exp_lat = 3; end
                3'd7: begin
                    a = ref_q.pop_back(); r = ~a; ref_q.push_back(r);
                    exp_res = r; exp_din = r; exp_npop = 1; exp_npush = 1; exp_lat = 4;
                    mz = (r == 8'h00); mc = 1'b0;
                end
                default: begin
                    a = ref_q.pop_back(); b = ref_q.pop_back(); c = 1'b0;
                    case (op)
                        3'd3: begin s9 = a + b; r = s9[7:0]; c = s9[8]; end
                        3'd4: begin r = b - a; c = (a > b); end
                        3'd5: r = a & b;
                        default: r = a | b;
                    endcase
                    ref_q.push_back(r);
                    exp_res = r; exp_din = r; exp_npop = 2; exp_npush = 1; exp_lat = 5;
                    mz = (r == 8'h00); mc = c;
                end
            endcase
        end
        exp_err_after = err_m; exp_zf = mz; exp_cf = mc;
        exp_depth_after = ref_q.size();
        for (int i = 0; i < 20 && !bus.cmd_ready; i++) @(negedge clk);
        if (!bus.cmd_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        bus.cmd_op = op; bus.cmd_imm = imm; bus.cmd_valid = 1'b1;
        @(posedge clk);
        lat = 0; n_push = 0; n_pop = 0; busy = 1;
        #1 bus.cmd_valid = 1'b0;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_imm = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {stk_push, stk_pop, stk_tos, bus.res_valid, bus.cmd_ready, err}, 32'd0);
        chk("rst_data", {stk_din, bus.res_data, 5'b0, depth}, 32'd0);
        rst = 1'b1;
        #1 chk("ready_before_edge", bus.cmd_ready, 1'b0);
        @(posedge clk); #1 chk("ready_after_release", bus.cmd_ready, 1'b1);
        @(negedge clk); in_reset = 0;

        send(3'd0, 8'h12); send(3'd0, 8'h34); send(3'd3, 8'h00);
        chk("add_res", last_res, 8'h46);
        @(negedge clk); chk("add_depth", depth, 3'd1);
        send(3'd1, 8'h00);

        send(3'd0, 8'h05); send(3'd0, 8'h07); send(3'd4, 8'h00);
        chk("sub_res", last_res, 8'hFE);
        send(3'd1, 8'h00);

        send(3'd1, 8'h00);
        chk("uflow_res", last_res, 8'h00);
        chk("uflow_err", err, 1'b1);
        send(3'd0, 8'hAA); send(3'd1, 8'h00);
        chk("after_fault_res", last_res, 8'hAA);

        for (int i = 1; i <= 5; i++) send(3'd0, 8'(i));
        send(3'd2, 8'h00);
        chk("oflow_res", last_res, 8'h00);
        send(3'd1, 8'h00);
        chk("pop5_res", last_res, 8'h05);
        @(negedge clk); chk("pop5_depth", depth, 3'd4);
        for (int i = 0; i < 4; i++) send(3'd1, 8'h00);

        send(3'd0, 8'h0F); send(3'd7, 8'h00); send(3'd2, 8'h00); send(3'd5, 8'h00);
        chk("and_res", last_res, 8'hF0);
        @(negedge clk); chk("and_depth", depth, 3'd1);
        send(3'd1, 8'h00);

        send(3'd0, 8'h30); send(3'd0, 8'h03); send(3'd6, 8'h00);
        chk("or_res", last_res, 8'h33);
        send(3'd0, 8'hFF); send(3'd0, 8'h01); send(3'd3, 8'h00);
        chk("add_wrap_res", last_res, 8'h00);
        send(3'd1, 8'h00); send(3'd3, 8'h00);
        send(3'd1, 8'h00); send(3'd7, 8'h00);

        // Reset while the second operand is being read.
        send(3'd0, 8'h11); send(3'd0, 8'h22);
        for (int i = 0; i < 20 && !bus.cmd_ready; i++) @(negedge clk);
        in_reset = 1;
        bus.cmd_op = 3'd3; bus.cmd_valid = 1'b1;
        @(posedge clk); #1 bus.cmd_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rdb_strobes", {stk_tos, stk_pop, stk_push}, 3'b110);
        rst = 1'b0;
        #1 chk("midrst_strobes", {stk_push, stk_pop, stk_tos, bus.res_valid, bus.cmd_ready}, 32'd0);
        chk("midrst_depth", depth, 3'd0);
        chk("midrst_err", err, 1'b0);
        ref_q.delete(); err_m = 1'b0; mz = 1'b0; mc = 1'b0;
        model_depth = 0; model_err = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1 chk("midrst_ready", bus.cmd_ready, 1'b1);
        @(negedge clk); in_reset = 0;
        send(3'd0, 8'h5A); send(3'd1, 8'h00);
        chk("post_rst_res", last_res, 8'h5A);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
